cmp_stream_ctrl: RTL and testbench
==================================

CMP_STREAM_CTRL -- requirements
Module: cmp_stream_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of each result tally counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair on in_a/in_b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in_a, in_b  input  3 each  operand pair to compare.
REQ-007 op_a, op_b  output  3 each  registered operands driven to the downstream 3-bit comparator's A and B.
REQ-008 cmp_gt, cmp_lt, cmp_eq  input  1 each  comparator result flags for op_a vs op_b.
REQ-009 out_valid  output  1  result on res_gt/res_lt/res_eq is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 res_gt, res_lt, res_eq  output  1 each  registered comparator result.
REQ-012 res_err  output  1  registered result flags were not exactly one-hot.
REQ-013 cnt_gt, cnt_lt, cnt_eq  output  CNT_W each  saturating tallies of accepted results.
REQ-014 cnt_clr  input  1  synchronous clear of all three tallies.

Function
REQ-015 FSM states: IDLE, SETTLE, HOLD; encoding is free.
REQ-016 in_ready is 1 only in IDLE; out_valid is 1 only in HOLD; both are driven combinationally from state.
REQ-017 IDLE: in_valid=1 latches in_a->op_a and in_b->op_b and moves to SETTLE; otherwise stay in IDLE with op_a/op_b held.
REQ-018 SETTLE: lasts exactly one cycle; on its closing edge, cmp_gt/lt/eq are captured into res_gt/lt/eq, res_err is computed, and the FSM moves to HOLD.
REQ-019 res_err is 1 when (cmp_gt+cmp_lt+cmp_eq) != 1 at capture.
REQ-020 HOLD: res_* are stable while out_ready=0; out_ready=1 completes the transfer and returns to IDLE on that edge.
REQ-021 Latency: in_valid accept edge to first out_valid cycle is 2 cycles. Minimum throughput is one result per 3 cycles.
REQ-022 op_a/op_b do not change from accept until the HOLD->IDLE edge.
REQ-023 Tallies update on the HOLD->IDLE transfer edge only.
  - res_gt=1 increments cnt_gt; res_lt=1 increments cnt_lt; res_eq=1 increments cnt_eq.
  - If res_err=1, no tally changes.
REQ-024 Each tally saturates at 2^CNT_W-1 and never wraps.
REQ-025 If cnt_clr=1 and a transfer occur on the same edge, cnt_clr wins: all tallies become 0 and the transfer's increment is dropped.
REQ-026 cnt_clr does not affect FSM state, op_*, or res_*.
REQ-027 in_valid during SETTLE or HOLD is ignored; no operand is latched.

Reset
REQ-028 rst_n=0 immediately forces the following, regardless of clk: state IDLE, in_ready=1, out_valid=0, op_a=op_b=0, res_gt=res_lt=res_eq=res_err=0, all tallies 0.
REQ-029 Reset asserted mid-transaction (SETTLE or HOLD) discards the pending result without incrementing any tally.
REQ-030 After rst_n deasserts, the first rising edge may accept an operand pair.

Verification
REQ-031 The bench drives cmp_* from a 3-bit comparator model (unsigned or behavioural) connected to op_a/op_b, plus an error-injection override.
REQ-032 Basic compare: in_a=5, in_b=2, out_ready=1.
  -> out_valid two cycles after accept, res_gt=1, res_lt=0, res_eq=0, cnt_gt=1.
REQ-033 Backpressure: in_a=3, in_b=3, out_ready=0 for 5 cycles, then 1.
  -> res_eq=1 stable for all HOLD cycles; in_ready=0 throughout; cnt_eq increments once, on the release edge.
REQ-034 Error: force cmp_gt=cmp_lt=1 at SETTLE.
  -> res_err=1; all tallies unchanged after transfer.
REQ-035 Saturation with CNT_W=2: five in_a=1, in_b=4 transfers.
  -> cnt_lt reaches 3 and holds at 3.
  -> cnt_clr on the same edge as a sixth transfer leaves cnt_lt=0.
REQ-036 Reset mid-HOLD: assert rst_n=0 between clock edges.
  -> out_valid=0 and op_a=0 before the next edge; tallies 0.
  -> a new pair is accepted on the first edge after release.

Source files
------------

// File: rtl/cmp_stream_ctrl.sv
// Sequences operand pairs through an external 3-bit comparator: latch the operands,
// let the comparator settle for one cycle, then hold the registered result until the consumer accepts it.
module cmp_stream_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_a,
  input  logic [2:0]       in_b,
  output logic [2:0]       op_a,
  output logic [2:0]       op_b,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_gt,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_err,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq,
  input  logic             cnt_clr,
  output logic [1:0]       state_dbg_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready and out_valid depend only on state, never on the partner's valid/ready.
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic             res_gt_q, res_gt_d, res_lt_q, res_lt_d;
  logic             res_eq_q, res_eq_d, res_err_q, res_err_d;
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d, cnt_lt_q, cnt_lt_d, cnt_eq_q, cnt_eq_d;
  logic             xfer_out;
  logic [1:0]       flag_sum;

  assign flag_sum = {1'b0, cmp_gt} + {1'b0, cmp_lt} + {1'b0, cmp_eq};
  assign xfer_out = (state_q == HOLD) && out_ready;

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_gt_d  = res_gt_q;
    res_lt_d  = res_lt_q;
    res_eq_d  = res_eq_q;
    res_err_d = res_err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        res_gt_d  = cmp_gt;
        res_lt_d  = cmp_lt;
        res_eq_d  = cmp_eq;
        res_err_d = (flag_sum != 2'd1);
        state_d   = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats a simultaneous transfer; a malformed result never counts.
  always_comb begin
    cnt_gt_d = cnt_gt_q;
    cnt_lt_d = cnt_lt_q;
    cnt_eq_d = cnt_eq_q;
    if (cnt_clr) begin
      cnt_gt_d = '0;
      cnt_lt_d = '0;
      cnt_eq_d = '0;
    end else if (xfer_out && !res_err_q) begin
      if (res_gt_q && (cnt_gt_q != {CNT_W{1'b1}})) cnt_gt_d = cnt_gt_q + CNT_W'(1);
      if (res_lt_q && (cnt_lt_q != {CNT_W{1'b1}})) cnt_lt_d = cnt_lt_q + CNT_W'(1);
      if (res_eq_q && (cnt_eq_q != {CNT_W{1'b1}})) cnt_eq_d = cnt_eq_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_gt_q  <= 1'b0;
      res_lt_q  <= 1'b0;
      res_eq_q  <= 1'b0;
      res_err_q <= 1'b0;
      cnt_gt_q  <= '0;
      cnt_lt_q  <= '0;
      cnt_eq_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_gt_q  <= res_gt_d;
      res_lt_q  <= res_lt_d;
      res_eq_q  <= res_eq_d;
      res_err_q <= res_err_d;
      cnt_gt_q  <= cnt_gt_d;
      cnt_lt_q  <= cnt_lt_d;
      cnt_eq_q  <= cnt_eq_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign res_gt      = res_gt_q;
  assign res_lt      = res_lt_q;
  assign res_eq      = res_eq_q;
  assign res_err     = res_err_q;
  assign cnt_gt      = cnt_gt_q;
  assign cnt_lt      = cnt_lt_q;
  assign cnt_eq      = cnt_eq_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_cmp_stream_ctrl.sv
// Directed bench for cmp_stream_ctrl with a 2-bit tally width so saturation is reachable.
module tb_cmp_stream_ctrl;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [2:0] in_a = '0, in_b = '0, op_a, op_b;
  logic cmp_gt, cmp_lt, cmp_eq;
  logic out_valid, out_ready = 1'b0;
  logic res_gt, res_lt, res_eq, res_err;
  logic [CNT_W-1:0] cnt_gt, cnt_lt, cnt_eq;
  logic cnt_clr = 1'b0;
  logic [1:0] state_dbg;

  logic inj = 1'b0, inj_gt = 1'b0, inj_lt = 1'b0, inj_eq = 1'b0;

  always #5 clk = ~clk;

  // Behavioural comparator with an override for error injection.
  assign cmp_gt = inj ? inj_gt : (op_a > op_b);
  assign cmp_lt = inj ? inj_lt : (op_a < op_b);
  assign cmp_eq = inj ? inj_eq : (op_a == op_b);

  cmp_stream_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op_a(op_a), .op_b(op_b),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_gt(res_gt), .res_lt(res_lt), .res_eq(res_eq), .res_err(res_err),
    .cnt_gt(cnt_gt), .cnt_lt(cnt_lt), .cnt_eq(cnt_eq), .cnt_clr(cnt_clr),
    .state_dbg_o(state_dbg)
  );

  int n_chk = 0;
  int n_bad = 0;
  int e_gt = 0, e_lt = 0, e_eq = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] flags;  // {gt, lt, eq}
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_cnts(input string name);
    check({name, "_cnt_gt"}, int'(cnt_gt), e_gt);
    check({name, "_cnt_lt"}, int'(cnt_lt), e_lt);
    check({name, "_cnt_eq"}, int'(cnt_eq), e_eq);
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge inside SETTLE.
  task automatic accept(input logic [2:0] a, input logic [2:0] b);
    check("accept_in_ready", int'(in_ready), 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("settle_out_valid", int'(out_valid), 0);
    check("settle_in_ready", int'(in_ready), 0);
    check("settle_op_a", int'(op_a), int'(a));
    check("settle_op_b", int'(op_b), int'(b));
  endtask

  // Bounded wait for out_valid; exactly one more edge is expected.
  task automatic wait_hold();
    int n = 0;
    while (!out_valid && n < 4) begin
      @(negedge clk); n++;
    end
    check("hold_latency", n, 1);
  endtask

  task automatic release_out(input logic clr);
    out_ready = 1'b1; cnt_clr = clr;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0; cnt_clr = 1'b0;
    check("post_xfer_in_ready", int'(in_ready), 1);
    check("post_xfer_out_valid", int'(out_valid), 0);
  endtask

  task automatic clear_tallies();
    cnt_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    cnt_clr = 1'b0;
    e_gt = 0; e_lt = 0; e_eq = 0;
    check_cnts("clr");
  endtask

  initial begin
    logic [2:0] f;
    vecs[0] = '{a: 3'd5, b: 3'd2, flags: 3'b100};
    vecs[1] = '{a: 3'd1, b: 3'd6, flags: 3'b010};
    vecs[2] = '{a: 3'd7, b: 3'd7, flags: 3'b001};
    vecs[3] = '{a: 3'd0, b: 3'd7, flags: 3'b010};
    vecs[4] = '{a: 3'd7, b: 3'd0, flags: 3'b100};
    vecs[5] = '{a: 3'd0, b: 3'd0, flags: 3'b001};

    // Reset state
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_op_a", int'(op_a), 0);
    check("rst_res", int'({res_gt, res_lt, res_eq, res_err}), 0);
    check_cnts("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven compares with immediate acceptance
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].flags);
      accept(vecs[i].a, vecs[i].b);
      wait_hold();
      f = exp_q.pop_front();
      check($sformatf("vec%0d_res", i), int'({res_gt, res_lt, res_eq}), int'(f));
      check($sformatf("vec%0d_err", i), int'(res_err), 0);
      release_out(1'b0);
      if (f[2]) e_gt = sat_inc(e_gt);
      if (f[1]) e_lt = sat_inc(e_lt);
      if (f[0]) e_eq = sat_inc(e_eq);
      check_cnts($sformatf("vec%0d", i));
    end

    // Backpressure: result held, extra in_valid ignored, tally on release only
    clear_tallies();
    accept(3'd3, 3'd3);
    wait_hold();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_a = 3'd6; in_b = 3'd1;
      check("bp_res_eq", int'(res_eq), 1);
      check("bp_res_gt_lt", int'({res_gt, res_lt}), 0);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_op_a", int'(op_a), 3);
      check("bp_cnt_eq", int'(cnt_eq), 0);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    release_out(1'b0);
    e_eq = 1;
    check_cnts("bp");

    // Error injection: both gt and lt asserted while settling
    accept(3'd4, 3'd2);
    inj = 1'b1; inj_gt = 1'b1; inj_lt = 1'b1; inj_eq = 1'b0;
    wait_hold();
    inj = 1'b0;
    check("err_res_err", int'(res_err), 1);
    release_out(1'b0);
    check_cnts("err");

    // No flags at all is also an error
    accept(3'd2, 3'd2);
    inj = 1'b1; inj_gt = 1'b0; inj_lt = 1'b0; inj_eq = 1'b0;
    wait_hold();
    inj = 1'b0;
    check("err0_res_err", int'(res_err), 1);
    release_out(1'b0);
    check_cnts("err0");

    // Saturation of cnt_lt, then clear colliding with a transfer
    clear_tallies();
    for (int k = 0; k < 5; k++) begin
      accept(3'd1, 3'd4);
      wait_hold();
      check("sat_res_lt", int'(res_lt), 1);
      release_out(1'b0);
      e_lt = sat_inc(e_lt);
      check($sformatf("sat%0d_cnt_lt", k), int'(cnt_lt), (k + 1 < CMAX) ? k + 1 : CMAX);
    end
    accept(3'd1, 3'd4);
    wait_hold();
    release_out(1'b1);
    e_gt = 0; e_lt = 0; e_eq = 0;
    check_cnts("clr_xfer");

    // Reset asserted mid-HOLD, between edges
    accept(3'd2, 3'd5);
    wait_hold();
    check("rh_pre_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    in_valid = 1'b1; in_a = 3'd6; in_b = 3'd1;
    #1;
    check("rh_out_valid", int'(out_valid), 0);
    check("rh_in_ready", int'(in_ready), 1);
    check("rh_op_a", int'(op_a), 0);
    check("rh_op_b", int'(op_b), 0);
    check("rh_res", int'({res_gt, res_lt, res_eq, res_err}), 0);
    check_cnts("rh");
    #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("rh_accept_op_a", int'(op_a), 6);
    check("rh_accept_in_ready", int'(in_ready), 0);
    wait_hold();
    check("rh_res_gt", int'(res_gt), 1);
    release_out(1'b0);
    e_gt = 1;
    check_cnts("rh_after");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
